instruction_loader: RTL

- Bootloader write-side companion to the instruction ROM.
- Accepts a byte stream (from a UART receiver) through a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction RAM through a single write port, then zero-fills the unused words.
- Holds the CPU in reset until a complete, checksum-verified image has been written.

---
 rtl/instruction_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Bootloader write side: assembles big-endian words from a byte stream, writes them to
// instruction RAM, zero-fills the rest and releases the CPU once the checksum matches.
//
// state  | meaning
// IDLE   | after reset, waiting for load_start
// COUNT  | waiting for the word-count byte N
// DATA   | shifting in data bytes, four per word
// WRITE  | one-cycle write of the assembled word
// CHECK  | waiting for the checksum byte
// CLEAR  | zero-filling words N..DEPTH-1, one per cycle
// DONE   | image loaded, CPU released
// ERROR  | bad count, bad checksum or timeout; CPU held
module instruction_loader #(
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_write,
   output logic [30:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error
);

   localparam int IW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
   localparam logic [8:0]    DEPTH_9 = 9'(DEPTH);
   localparam logic [TW-1:0] TLIMIT  = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_CLEAR, S_DONE, S_ERROR
   } state_t;

   state_t        state, state_next;
   logic [IW-1:0] index, n_words, index_inc;
   logic [1:0]    bcnt;
   logic [7:0]    csum;
   logic [31:0]   asm_word;
   logic [TW-1:0] tcount, tcount_inc;
   logic          xfer, in_rx, timed_out, count_bad;

   assign xfer       = byte_valid && byte_ready;
   assign in_rx      = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
   assign tcount_inc = tcount + 1'b1;
   assign timed_out  = in_rx && !xfer && (tcount_inc == TLIMIT);
   assign index_inc  = index + 1'b1;
   assign count_bad  = (byte_data == 8'd0) || ({1'b0, byte_data} > DEPTH_9);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (load_start) begin
         state_next = S_COUNT;
      end else if (timed_out) begin
         state_next = S_ERROR;
      end else begin
         case (state)
            S_COUNT: if (xfer) state_next = count_bad ? S_ERROR : S_DATA;
            S_DATA:  if (xfer && bcnt == 2'd3) state_next = S_WRITE;
            S_WRITE: state_next = (index_inc == n_words) ? S_CHECK : S_DATA;
            S_CHECK: if (xfer) begin
               if (byte_data != csum)        state_next = S_ERROR;
               else if (n_words == DEPTH_I)  state_next = S_DONE;
               else                          state_next = S_CLEAR;
            end
            S_CLEAR: if (index_inc == DEPTH_I) state_next = S_DONE;
            default: state_next = state;
         endcase
      end
   end

   // Outputs are registered from the next state so they align with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_ready     <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         cpu_hold       <= 1'b1;
         load_done      <= 1'b0;
         load_error     <= 1'b0;
         index          <= '0;
         n_words        <= '0;
         bcnt           <= '0;
         csum           <= '0;
         asm_word       <= '0;
         tcount         <= '0;
      end else begin
         byte_ready <= (state_next == S_COUNT) || (state_next == S_DATA) ||
                       (state_next == S_CHECK);
         mem_write  <= (state_next == S_WRITE) || (state_next == S_CLEAR);
         cpu_hold   <= (state_next != S_DONE);
         load_done  <= (state_next == S_DONE);
         load_error <= (state_next == S_ERROR);
         if (load_start) begin
            index  <= '0;
            bcnt   <= '0;
            csum   <= '0;
            tcount <= '0;
         end else begin
            if (in_rx) tcount <= xfer ? '0 : tcount_inc;
            case (state)
               S_COUNT: if (xfer) n_words <= IW'(byte_data);
               S_DATA: if (xfer) begin
                  asm_word <= {asm_word[23:0], byte_data};
                  csum     <= csum ^ byte_data;
                  bcnt     <= bcnt + 1'b1;
                  if (bcnt == 2'd3) begin
                     mem_write_data <= {asm_word[23:0], byte_data};
                     mem_address    <= 31'({index, 2'b00});
                  end
               end
               S_WRITE: index <= index_inc;
               S_CHECK: if (xfer && byte_data == csum && n_words != DEPTH_I) begin
                  mem_write_data <= '0;
                  mem_address    <= 31'({index, 2'b00});
               end
               S_CLEAR: begin
                  index       <= index_inc;
                  mem_address <= 31'({index_inc, 2'b00});
               end
               default: ;
            endcase
         end
      end
   end

endmodule
